wb_arbiter2: RTL
================

# wb_arbiter2

Two-master, one-slave Wishbone (classic, non-pipelined) arbiter that shares the SoC slave bus between the LM32 instruction and data masters. It grants the bus for a whole `cyc` period, rotates priority round-robin on release, and forces an error response when a slave fails to acknowledge within a bounded number of cycles. It sits between the CPU ports and the address decoder feeding UART, GPIO, timer and RAM.

## Interface
- `adr_width`, 32, address width of all `adr` ports
- `dat_width`, 32, data width; `sel` width is `dat_width/8`
- `timeout`, 255, cycles of unacknowledged `s_stb` before a forced error; range 1..65535

Ports. x is 0 (instruction master) or 1 (data master).
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mx_cyc`  in  1  master x bus-cycle request and lock
- `mx_stb`  in  1  master x strobe
- `mx_we`  in  1  master x write enable
- `mx_adr`  in  adr_width  master x address
- `mx_sel`  in  dat_width/8  master x byte selects
- `mx_dat_w`  in  dat_width  master x write data
- `mx_dat_r`  out  dat_width  read data, equal to `s_dat_r` for both masters
- `mx_ack`  out  1  acknowledge, granted master only
- `mx_err`  out  1  error, slave error or timeout, granted master only
- `s_cyc`, `s_stb`, `s_we`  out  1  to slave
- `s_adr`  out  adr_width  to slave
- `s_sel`  out  dat_width/8  to slave
- `s_dat_w`  out  dat_width  to slave
- `s_dat_r`  in  dat_width  from slave
- `s_ack`, `s_err`  in  1  from slave
- `gnt`  out  2  one-hot current grant, debug; 00 = idle

## Operation
- States: IDLE, GNT0, GNT1. A `last` register holds the most recently granted master and resets to 1, so master 0 wins the first tie.
- IDLE: if only mx_cyc is high, go to GNTx. If both are high, grant the master not equal to `last`. If neither is high, stay in IDLE.
- GNTx: hold while mx_cyc=1. Holding across deasserted `stb` gives a locked burst. On mx_cyc=0:
  - if the other master's cyc=1, go directly to GNT(other);
  - otherwise go to IDLE.
  - Either way, set `last`=x.
- Muxing in GNTx: all s_* outputs equal master x's signals, with `s_cyc`=mx_cyc and `s_stb`=mx_stb. mx_ack = s_ack, and mx_err = s_err OR timeout pulse. The non-granted master sees ack=err=0.
- Muxing in IDLE: s_cyc=s_stb=s_we=0. s_adr, s_sel and s_dat_w are 0. s_ack and s_err are ignored.
- Timeout counter (16 bit):
  - clears on reset, on state change, on s_ack or s_err, and when s_stb=0;
  - increments on each cycle with s_cyc&s_stb and no ack/err.
- Timeout response: when counter==timeout, drive a 1-cycle mx_err pulse to the granted master, force s_stb=0 in that same cycle, and clear the counter. The grant is kept until the master drops cyc.
- A slave ack/err that coincides with a timeout cycle is delivered as given; the counter clears and no extra pulse is generated.
- Stray s_ack/s_err while IDLE is dropped silently.

## Timing
- Reset (async, rst=0): state=IDLE, last=1, counter=0, gnt=00. All s_* outputs, mx_ack and mx_err are 0 immediately, without waiting for a clock edge.
- Reset mid-transfer: s_cyc drops asynchronously. After rst rises, arbitration restarts from IDLE.
- Grant latency: mx_cyc rising seen at edge N gives s_cyc=1 after edge N+1, i.e. one arbitration cycle.
- Handoff: the other master drives the slave the cycle after the owner drops cyc. There is no idle gap.
- Data path is combinational (no added latency): s_ack to mx_ack is 0 cycles, and mx_stb to s_stb is 0 cycles once granted.
- Timeout: with s_stb high from edge N and no ack, mx_err asserts in the cycle after edge N+timeout.

## Test plan
- Reset then idle: hold rst=0 and drive m0_cyc=1 -> s_cyc=0 and gnt=00. Release rst -> gnt=01 one clock later.
- Single read: m1 reads adr 0x1000 and the slave acks after 2 cycles with data 0xDEADBEEF -> m1_ack=1 and m1_dat_r=0xDEADBEEF in that cycle, m0_ack=0.
- Tie after reset: m0_cyc and m1_cyc rise together -> gnt=01. After m0 drops cyc, gnt=10 with no idle cycle. On the next simultaneous request from IDLE, gnt=01.
- Locked burst: m1 holds cyc for 4 single-cycle writes with stb gaps while m0_cyc=1 -> gnt stays 10 throughout, and m0 never sees ack.
- Timeout: timeout=8 and the slave never acks an m0 read -> m0_err pulses exactly 1 cycle, 8 cycles after stb is first sampled, with s_stb=0 in that cycle. The grant is released when m0 drops cyc.
- Async reset during an m1 write -> s_cyc and m1_ack go to 0 immediately, gnt=00. After release, m0 is granted first.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave classic Wishbone arbiter. Round-robin grant held for a whole
// cyc period, with a watchdog that turns a silent slave into an error response.
module wb_arbiter2 #(
  parameter int adr_width = 32,
  parameter int dat_width = 32,
  parameter int timeout   = 255
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   m0_cyc,
  input  logic                   m0_stb,
  input  logic                   m0_we,
  input  logic [adr_width-1:0]   m0_adr,
  input  logic [dat_width/8-1:0] m0_sel,
  input  logic [dat_width-1:0]   m0_dat_w,
  output logic [dat_width-1:0]   m0_dat_r,
  output logic                   m0_ack,
  output logic                   m0_err,

  input  logic                   m1_cyc,
  input  logic                   m1_stb,
  input  logic                   m1_we,
  input  logic [adr_width-1:0]   m1_adr,
  input  logic [dat_width/8-1:0] m1_sel,
  input  logic [dat_width-1:0]   m1_dat_w,
  output logic [dat_width-1:0]   m1_dat_r,
  output logic                   m1_ack,
  output logic                   m1_err,

  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [adr_width-1:0]   s_adr,
  output logic [dat_width/8-1:0] s_sel,
  output logic [dat_width-1:0]   s_dat_w,
  input  logic [dat_width-1:0]   s_dat_r,
  input  logic                   s_ack,
  input  logic                   s_err,

  output logic [1:0]             gnt
);

  localparam int          sel_width = dat_width / 8;
  localparam logic [15:0] tmo_limit = 16'(timeout);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic                 own_cyc;
  logic                 own_stb;
  logic                 own_we;
  logic [adr_width-1:0] own_adr;
  logic [sel_width-1:0] own_sel;
  logic [dat_width-1:0] own_dat_w;
  logic                 granted;
  logic                 tmo;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values of its inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_cyc) begin
          state_d = GNT0;
        end else if (m1_cyc) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc) begin
          last_d  = 1'b0;
          state_d = m1_cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          last_d  = 1'b1;
          state_d = m0_cyc ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the owning master's request; IDLE presents an all-zero request.
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_adr   = '0;
    own_sel   = '0;
    own_dat_w = '0;
    granted   = 1'b0;
    case (state_q)
      GNT0: begin
        own_cyc   = m0_cyc;
        own_stb   = m0_stb;
        own_we    = m0_we;
        own_adr   = m0_adr;
        own_sel   = m0_sel;
        own_dat_w = m0_dat_w;
        granted   = 1'b1;
      end
      GNT1: begin
        own_cyc   = m1_cyc;
        own_stb   = m1_stb;
        own_we    = m1_we;
        own_adr   = m1_adr;
        own_sel   = m1_sel;
        own_dat_w = m1_dat_w;
        granted   = 1'b1;
      end
      default: ;
    endcase
  end

  // A real slave response in the limit cycle wins; the watchdog stays silent then.
  assign tmo = granted && own_cyc && own_stb && (cnt_q == tmo_limit) && !s_ack && !s_err;

  assign s_cyc   = own_cyc;
  assign s_stb   = own_stb && !tmo;
  assign s_we    = own_we;
  assign s_adr   = own_adr;
  assign s_sel   = own_sel;
  assign s_dat_w = own_dat_w;

  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign m0_ack   = (state_q == GNT0) && s_ack;
  assign m1_ack   = (state_q == GNT1) && s_ack;
  assign m0_err   = (state_q == GNT0) && (s_err || tmo);
  assign m1_err   = (state_q == GNT1) && (s_err || tmo);

  assign gnt = {state_q == GNT1, state_q == GNT0};

  // The forced s_stb=0 in the timeout cycle also clears the counter.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || s_ack || s_err || !s_stb) begin
      cnt_d = '0;
    end else if (s_cyc) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

endmodule
